// File: rtl/aes_io_pkg.sv
// -----------------------------------------------------------------------------
// aes_io_pkg
// Shared constants and types for the AES block I/O stages (byte packer and
// the 128-to-8 parallel-in/serial-out stage).
//   BYTE_W      : bits per byte lane
//   BLK_BYTES   : bytes per AES block
//   BLK_W       : bits per AES block
//   piso_state_e: serializer states
// -----------------------------------------------------------------------------
package aes_io_pkg;

    localparam int BYTE_W    = 8;
    localparam int BLK_BYTES = 16;
    localparam int BLK_W     = BYTE_W * BLK_BYTES;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } piso_state_e;

    // Plain-vector copies of the state codes for the state register
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_SEND = SEND;

endpackage

// File: rtl/piso_128to8_if.sv
// -----------------------------------------------------------------------------
// piso_128to8_if
// Block-in / byte-out handshake bundle for piso_128to8.
//   clear     : synchronous abort (producer side drives)
//   in_valid  : block on `in` is valid
//   in_ready  : stage accepts a block this cycle
//   in        : parallel 128-bit block
//   out_valid : `out` holds a byte
//   out_ready : downstream accepts the byte
//   out       : current byte
//   out_last  : current byte is the final byte of its block
//   busy      : block in flight or buffered block pending
// Modports: master = environment driving the stage, slave = the stage itself.
// -----------------------------------------------------------------------------
interface piso_128to8_if
    import aes_io_pkg::*;
#(
    parameter int out_N = BYTE_W,
    parameter int set_N = BLK_BYTES
);
    logic                     clear;
    logic                     in_valid;
    logic                     in_ready;
    logic [out_N*set_N-1:0]   in;
    logic                     out_valid;
    logic                     out_ready;
    logic [out_N-1:0]         out;
    logic                     out_last;
    logic                     busy;

    modport master (
        output clear, in_valid, in, out_ready,
        input  in_ready, out_valid, out, out_last, busy
    );

    modport slave (
        input  clear, in_valid, in, out_ready,
        output in_ready, out_valid, out, out_last, busy
    );

endinterface

// File: rtl/piso_128to8_blk_hold_reg.sv
// -----------------------------------------------------------------------------
// blk_hold_reg
// One-deep block buffer: a W-bit data register plus a full flag.
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset
//   load_i  : capture d_i and mark full
//   take_i  : consumer has taken q_o; mark empty
//   flush_i : discard contents (highest priority)
//   d_i     : block to capture
//   q_o     : buffered block
//   full_o  : buffer holds a block
// -----------------------------------------------------------------------------
module blk_hold_reg
    import aes_io_pkg::*;
#(
    parameter int W = BLK_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         take_i,
    input  logic         flush_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic         full_o
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    // load and take are mutually exclusive: load needs an empty buffer,
    // take needs a full one.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (flush_i) begin
            full_d = 1'b0;
            data_d = '0;
        end else if (load_i) begin
            full_d = 1'b1;
            data_d = d_i;
        end else if (take_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign q_o    = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/piso_128to8.sv
// -----------------------------------------------------------------------------
// piso_128to8
// Parallel-in/serial-out stage at the output of the AES datapath. Accepts a
// 128-bit block and streams it out one byte per handshake, byte 0 (bits
// [7:0]) first, byte 15 (bits [127:120]) last and flagged with out_last.
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : piso_128to8_if.slave (clear, in_valid/in_ready/in,
//           out_valid/out_ready/out/out_last, busy)
//
// Build option PISO_HOLD_BUF_EN: adds a one-block hold buffer so a second
// block can be accepted while the first is streaming, removing the bubble
// between back-to-back blocks. Without it the stage only accepts in IDLE.
// -----------------------------------------------------------------------------
module piso_128to8
    import aes_io_pkg::*;
#(
    parameter int out_N = BYTE_W,
    parameter int set_N = BLK_BYTES
) (
    input logic           clk,
    input logic           reset,
    piso_128to8_if.slave  bus
);

    localparam int         in_N     = out_N * set_N;
    localparam logic [4:0] CNT_LAST = 5'(set_N - 1);

    logic [0:0]      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [in_N-1:0] shreg_q, shreg_d;

    logic in_acc;
    logic out_hs;
    logic last_hs;

    assign in_acc  = bus.in_valid && bus.in_ready;
    assign out_hs  = (state_q == ST_SEND) && bus.out_ready;
    assign last_hs = out_hs && (cnt_q == CNT_LAST);

`ifdef PISO_HOLD_BUF_EN
    logic            hold_full;
    logic [in_N-1:0] hold_q;
    logic            hold_load;
    logic            hold_take;

    assign bus.in_ready = !hold_full && !bus.clear;
    // A block accepted while streaming goes to the hold buffer, except on the
    // last-byte handshake with an empty buffer, where it goes straight into
    // the shift register.
    assign hold_load    = in_acc && (state_q == ST_SEND) && !last_hs;
    assign hold_take    = last_hs && hold_full;
    assign bus.busy     = (state_q == ST_SEND) || hold_full;

    blk_hold_reg #(
        .W (in_N)
    ) u_hold (
        .clk     (clk),
        .reset   (reset),
        .load_i  (hold_load),
        .take_i  (hold_take),
        .flush_i (bus.clear),
        .d_i     (bus.in),
        .q_o     (hold_q),
        .full_o  (hold_full)
    );
`else
    assign bus.in_ready = (state_q == ST_IDLE) && !bus.clear;
    assign bus.busy     = (state_q == ST_SEND);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (bus.clear) begin
            // Abort wins over both handshakes in the same cycle
            state_d = ST_IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end else if (state_q == ST_IDLE) begin
            if (in_acc) begin
                shreg_d = bus.in;
                cnt_d   = '0;
                state_d = ST_SEND;
            end
        end else if (out_hs) begin
            if (cnt_q != CNT_LAST) begin
                shreg_d = shreg_q >> out_N;
                cnt_d   = cnt_q + 5'd1;
            end else begin
                cnt_d = '0;
`ifdef PISO_HOLD_BUF_EN
                if (hold_full) begin
                    shreg_d = hold_q;
                end else if (in_acc) begin
                    shreg_d = bus.in;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Outputs come from registers only; out_ready never reaches out.
    assign bus.out_valid = (state_q == ST_SEND);
    assign bus.out       = shreg_q[out_N-1:0];
    assign bus.out_last  = (state_q == ST_SEND) && (cnt_q == CNT_LAST);

endmodule

// File: doc/piso_128to8.md
# piso_128to8

Parallel-in/serial-out stage that takes a 128-bit AES result block and streams it out one byte per handshake. It sits at the output of the AES datapath and mirrors the input byte packer: byte 0 is bits [7:0], byte 15 is bits [127:120], and byte 0 is sent first. It includes a valid/ready handshake on both sides, a last-byte marker, a synchronous abort, and optional block double-buffering.

## Interface
Parameters:
- `out_N`, 8: byte width in bits.
- `set_N`, 16: bytes per block.
- `in_N`, `out_N*set_N` (128): block width. Derived; never overridden.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous abort; drops the block in flight and any buffered block.
- `in_valid`  in  1: `in` holds a block to load.
- `in_ready`  out  1: stage can accept a block this cycle.
- `in`  in  in_N: parallel block.
- `out_valid`  out  1: `out` holds a byte.
- `out_ready`  in  1: downstream accepts the byte.
- `out`  out  out_N: current byte.
- `out_last`  out  1: current byte is byte set_N-1 of its block.
- `busy`  out  1: block in flight, or buffered block pending.

## Operation
- States: IDLE and SEND. Counter `cnt` is 5 bits, range 0..set_N-1.
- IDLE:
  - `in_ready`=1 and `out_valid`=0.
  - When `in_valid`&`in_ready`: shift register <= `in`, `cnt`<=0, go to SEND.
- SEND:
  - `out_valid`=1, `out`=shift register[out_N-1:0], `out_last`=(`cnt`==set_N-1).
  - On an output handshake with `cnt`<set_N-1: shift right by out_N (zero fill) and `cnt`++.
  - On an output handshake with `cnt`==set_N-1: go to IDLE, or reload from the hold buffer (see Configuration).
- Stall: while `out_valid`&!`out_ready`, `out`, `out_last` and `cnt` hold.
- `busy` = (state==SEND) | hold-buffer full.
- `clear`:
  - Next state is IDLE; `cnt`=0; shift register=0; hold buffer emptied.
  - Has priority over both handshakes in the same cycle; `in_ready` is forced 0 while `clear`=1.
- Arithmetic: `cnt` never exceeds set_N-1; no wrap occurs.

## Timing
- Reset values: `out_valid`=0, `out`=0, `out_last`=0, `busy`=0, `in_ready`=1, state IDLE, `cnt`=0.
- Load latency: block accepted at edge T; byte 0 is valid after T, so it is visible in cycle T+1.
- Throughput: one byte per cycle while `out_ready`=1, so 16 cycles per block.
- Without hold buffer: last byte accepted at T; `in_ready` rises at T+1; the next byte 0 appears at T+2 at the earliest. Minimum gap is one bubble cycle.
- With hold buffer: no bubble between back-to-back blocks.
- Outputs are driven combinationally from registers only; no combinational path from `out_ready` to `out`.
- Reset asserted mid-block: everything returns to reset values asynchronously; the partial block is lost.

## Configuration
- `PISO_HOLD_BUF_EN` defined:
  - Adds a 128-bit hold register plus a full flag.
  - `in_ready` = !full.
  - Accept in IDLE loads the shift register directly. Accept in SEND loads the hold register and sets full.
  - On the last-byte handshake with full=1: shift register <= hold, `cnt`<=0, full<=0, stay in SEND.
  - Simultaneous last-byte handshake and input accept with full=0: the incoming block goes straight into the shift register.
- Undefined: no hold register; `in_ready` = (state==IDLE)&!`clear`.

## Structure
- Shared package `aes_io_pkg`: byte width (8), bytes per block (16), block width (128), state enum {IDLE, SEND}.
- One sub-module: `blk_hold_reg` (128-bit register plus full flag with load/take/flush), instantiated only under `PISO_HOLD_BUF_EN`.

## Test plan
- Reset, then load `in`=128'h0F0E0D0C0B0A09080706050403020100 with `out_ready`=1 -> `out` = 00,01,...,0F on 16 consecutive cycles; `out_last`=1 only on 0F; `in_ready`=1 again one cycle after 0F.
- Same block, `out_ready` toggled 1,0,1,0 -> each byte held stable while stalled; no byte skipped or duplicated.
- `clear` pulsed after byte 05 -> `out_valid`=0 next cycle, `busy`=0; a new block then starts at its byte 0.
- `reset` driven low at byte 09 -> all outputs at reset values immediately; no further bytes emitted.
- With `PISO_HOLD_BUF_EN`: two blocks presented back-to-back, `out_ready`=1 -> 32 contiguous bytes with no bubble; `in_ready`=0 while the buffer is full.
- Without `PISO_HOLD_BUF_EN`: same stimulus -> exactly one idle cycle between byte 15 of block 1 and byte 0 of block 2.
